// File: rtl/axil_shadow_regfile_if.sv
// AXI-Lite bus bundle for axil_shadow_regfile.
// Carries the five AXI-Lite channels; master drives requests, slave drives responses.
interface axil_shadow_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_shadow_regfile.sv
// AXI-Lite shadow register file for the fractal pixel pipeline.
// Software writes land in a staging bank; the staging bank is copied to the
// active bank only on frame_sof while a write is pending, so downstream
// blocks never see parameters change mid-frame.
// Optional feature macro: REGFILE_FRAME_COUNT_EN adds a read-only commit
// counter at word index REG_COUNT.
module axil_shadow_regfile #(
    parameter int unsigned REG_COUNT           = 8,
    parameter int unsigned AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    axil_shadow_regfile_if.slave    s_axi_lite,
    input  logic                    frame_sof,
    output logic [32*REG_COUNT-1:0] regs_active,
    output logic                    regs_pending,
    output logic                    commit
);
    localparam int unsigned IDX_W = AXI_LITE_ADDR_WIDTH - 2;
    // Wide enough to hold the full word index and REG_COUNT without truncation.
    localparam int unsigned CMP_W = IDX_W + 8;

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_WRITE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_READ} r_state_t;

    w_state_t r_wstate, w_wstate_nxt;
    r_state_t r_rstate, w_rstate_nxt;

    logic [IDX_W-1:0]       r_aw_idx;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;
    logic [1:0]             r_bresp;
    logic [IDX_W-1:0]       r_ar_idx;
    logic [31:0]            r_rdata;
    logic [1:0]             r_rresp;
    logic [32*REG_COUNT-1:0] r_stage;
    logic [32*REG_COUNT-1:0] r_active;
    logic                   r_pending;
    logic                   r_commit;
`ifdef REGFILE_FRAME_COUNT_EN
    logic [31:0]            r_frame_cnt;
`endif

    logic             w_awready;
    logic             w_wready;
    logic             w_bvalid;
    logic             w_arready;
    logic             w_rvalid;
    logic [CMP_W-1:0] w_aw_idx_ext;
    logic [CMP_W-1:0] w_ar_idx_ext;
    logic             w_aw_in_range;
    logic             w_do_write;
    logic             w_commit_now;
    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;
    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^{s_axi_lite.awaddr[1:0], s_axi_lite.araddr[1:0]};

    assign w_aw_idx_ext  = CMP_W'(r_aw_idx);
    assign w_ar_idx_ext  = CMP_W'(r_ar_idx);
    assign w_aw_in_range = (w_aw_idx_ext < CMP_W'(REG_COUNT));
    assign w_do_write    = (r_wstate == W_WRITE) && w_aw_in_range;
    assign w_commit_now  = frame_sof && r_pending;

    // Write FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state: address and data may arrive together or in either order.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (s_axi_lite.awvalid && s_axi_lite.wvalid) w_wstate_nxt = W_WRITE;
                else if (s_axi_lite.awvalid)                 w_wstate_nxt = W_DATA;
                else if (s_axi_lite.wvalid)                  w_wstate_nxt = W_ADDR;
            end
            W_DATA:  if (s_axi_lite.wvalid)  w_wstate_nxt = W_WRITE;
            W_ADDR:  if (s_axi_lite.awvalid) w_wstate_nxt = W_WRITE;
            W_WRITE: w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_lite.bready)  w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: readies follow state and are held low during reset.
    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        if (!areset) begin
            w_awready = (r_wstate == W_IDLE) || (r_wstate == W_ADDR);
            w_wready  = (r_wstate == W_IDLE) || (r_wstate == W_DATA);
        end
        w_bvalid = (r_wstate == W_RESP);
    end

    // Capture write address/data on their handshakes and the response in W_WRITE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= '0;
        end else begin
            if (s_axi_lite.awvalid && w_awready) r_aw_idx <= s_axi_lite.awaddr[AXI_LITE_ADDR_WIDTH-1:2];
            if (s_axi_lite.wvalid && w_wready) begin
                r_wdata <= s_axi_lite.wdata;
                r_wstrb <= s_axi_lite.wstrb;
            end
            if (r_wstate == W_WRITE) r_bresp <= w_aw_in_range ? 2'b00 : 2'b10;
        end
    end

    // Staging bank: byte-strobed update of the addressed register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_stage <= '0;
        end else if (w_do_write) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if ((w_aw_idx_ext == CMP_W'(i)) && r_wstrb[k])
                        r_stage[32*i+8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    // Commit: active takes the pre-write staging; a same-cycle write keeps pending set.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_active  <= '0;
            r_pending <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= w_commit_now;
            if (w_commit_now) r_active <= r_stage;
            if (w_do_write)        r_pending <= 1'b1;
            else if (w_commit_now) r_pending <= 1'b0;
        end
    end

`ifdef REGFILE_FRAME_COUNT_EN
    // Commit counter, wraps naturally at 32 bits.
    always_ff @(posedge aclk) begin
        if (areset)            r_frame_cnt <= '0;
        else if (w_commit_now) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
`endif

    // Read FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state: one fetch cycle between address and data.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (s_axi_lite.arvalid) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_READ;
            R_READ:  if (s_axi_lite.rready)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        w_arready = (r_rstate == R_IDLE) && !areset;
        w_rvalid  = (r_rstate == R_READ);
    end

    // Read mux over the staging bank (and the commit counter when present).
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = 2'b10;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (w_ar_idx_ext == CMP_W'(i)) begin
                w_rd_data = r_stage[32*i +: 32];
                w_rd_resp = 2'b00;
            end
        end
`ifdef REGFILE_FRAME_COUNT_EN
        if (w_ar_idx_ext == CMP_W'(REG_COUNT)) begin
            w_rd_data = r_frame_cnt;
            w_rd_resp = 2'b00;
        end
`endif
    end

    // Latch read index on the AR handshake and register read data in R_FETCH.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ar_idx <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            if (s_axi_lite.arvalid && w_arready) r_ar_idx <= s_axi_lite.araddr[AXI_LITE_ADDR_WIDTH-1:2];
            if (r_rstate == R_FETCH) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign s_axi_lite.awready = w_awready;
    assign s_axi_lite.wready  = w_wready;
    assign s_axi_lite.bvalid  = w_bvalid;
    assign s_axi_lite.bresp   = r_bresp;
    assign s_axi_lite.arready = w_arready;
    assign s_axi_lite.rvalid  = w_rvalid;
    assign s_axi_lite.rdata   = r_rdata;
    assign s_axi_lite.rresp   = r_rresp;

    assign regs_active  = r_active;
    assign regs_pending = r_pending;
    assign commit       = r_commit;
endmodule

// File: tb/tb_axil_shadow_regfile.sv
// Directed self-checking bench for axil_shadow_regfile.
// Expected responses come from a small model of staging/active/pending/count.
`timescale 1ns/1ps
module tb_axil_shadow_regfile;
    localparam int unsigned REGS = 8;
    localparam int unsigned AW   = 8;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 frame_sof;
    logic [32*REGS-1:0]   regs_active;
    logic                 regs_pending;
    logic                 commit;

    axil_shadow_regfile_if #(.ADDR_WIDTH(AW)) bus ();

    axil_shadow_regfile #(
        .REG_COUNT(REGS),
        .AXI_LITE_ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axi_lite(bus.slave),
        .frame_sof(frame_sof),
        .regs_active(regs_active),
        .regs_pending(regs_pending),
        .commit(commit)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  q_b [$];
    logic [33:0] q_r [$];

    logic [31:0] m_stage  [REGS];
    logic [31:0] m_active [REGS];
    logic        m_pending;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < int'(REGS); i++)
            chk($sformatf("%s_active%0d", tag, i), 64'(regs_active[32*i +: 32]), 64'(m_active[i]));
    endtask

    function automatic logic [33:0] model_read(input logic [AW-1:0] addr);
        int unsigned idx;
        idx = 32'(addr) >> 2;
        if (idx < REGS) return {2'b00, m_stage[idx]};
`ifdef REGFILE_FRAME_COUNT_EN
        if (idx == REGS) return {2'b00, m_count};
`endif
        return {2'b10, 32'h0};
    endfunction

    // Write with independent address/data delays, optional bready hold and
    // optional frame_sof asserted during the W_WRITE cycle.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int hold, input bit sof_in_write);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs, committed;
        int c = 0;
        int n = 0;
        int unsigned idx;
        idx = 32'(addr) >> 2;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = (aw_delay == 0);
        bus.wvalid  = (w_delay == 0);
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge aclk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
            c++;
            if (!aw_done && c == aw_delay) bus.awvalid = 1'b1;
            if (!w_done && c == w_delay)   bus.wvalid  = 1'b1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("wr_handshake", 64'(aw_done && w_done), 64'd1);
        q_b.push_back((idx < REGS) ? 2'b00 : 2'b10);

        // Model: a coincident commit sees the pre-write staging.
        committed = sof_in_write && m_pending;
        if (committed) begin
            for (int i = 0; i < int'(REGS); i++) m_active[i] = m_stage[i];
            m_pending = 1'b0;
            m_count++;
        end
        if (idx < REGS) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) m_stage[idx][8*k +: 8] = data[8*k +: 8];
            m_pending = 1'b1;
        end

        if (sof_in_write) frame_sof = 1'b1;
        while (!bus.bvalid && n < 20) begin
            tick();
            if (n == 0 && sof_in_write) begin
                frame_sof = 1'b0;
                chk("sof_write_commit", 64'(commit), 64'(committed));
            end
            n++;
        end
        frame_sof = 1'b0;
        chk("b_latency", 64'(n), 64'd1);
        for (int h = 0; h < hold; h++) begin
            chk("b_hold_valid", 64'(bus.bvalid), 64'd1);
            chk("b_hold_resp", 64'(bus.bresp), 64'(q_b[0]));
            tick();
        end
        chk("bresp", 64'(bus.bresp), 64'(q_b.pop_front()));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_done", 64'(bus.bvalid), 64'd0);
        chk("pending_after_write", 64'(regs_pending), 64'(m_pending));
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit hs = 1'b0;
        int c = 0;
        int n = 0;
        logic [33:0] e;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!hs && c < 50) begin
            @(negedge aclk);
            hs = bus.arready;
            tick();
            c++;
        end
        bus.arvalid = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
        q_r.push_back({exp_resp, exp_data});
        // AR handshake edge, then one R_FETCH cycle before rvalid.
        while (!bus.rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("r_latency", 64'(n), 64'd1);
        e = q_r.pop_front();
        chk($sformatf("rdata_%0h", addr), 64'(bus.rdata), 64'(e[31:0]));
        chk($sformatf("rresp_%0h", addr), 64'(bus.rresp), 64'(e[33:32]));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("r_done", 64'(bus.rvalid), 64'd0);
    endtask

    task automatic rd_model(input logic [AW-1:0] addr);
        logic [33:0] e;
        e = model_read(addr);
        axi_read(addr, e[31:0], e[33:32]);
    endtask

    task automatic pulse_sof();
        bit exp_c;
        exp_c = m_pending;
        frame_sof = 1'b1;
        tick();
        frame_sof = 1'b0;
        if (exp_c) begin
            for (int i = 0; i < int'(REGS); i++) m_active[i] = m_stage[i];
            m_pending = 1'b0;
            m_count++;
        end
        chk("commit_pulse", 64'(commit), 64'(exp_c));
        chk("pending_after_sof", 64'(regs_pending), 64'd0);
        check_active("sof");
        tick();
        chk("commit_single", 64'(commit), 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(REGS); i++) begin
            m_stage[i]  = '0;
            m_active[i] = '0;
        end
        m_pending = 1'b0;
        m_count   = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areset      = 1'b1;
        frame_sof   = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        model_reset();
        repeat (3) tick();

        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_wready", 64'(bus.wready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd0);
        chk("rst_rresp", 64'(bus.rresp), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_pending", 64'(regs_pending), 64'd0);
        chk("rst_commit", 64'(commit), 64'd0);
        check_active("rst");

        areset = 1'b0;
        tick();
        chk("idle_awready", 64'(bus.awready), 64'd1);
        chk("idle_arready", 64'(bus.arready), 64'd1);

        // Byte strobes over an initial zero.
        axi_write(8'h04, 32'hDEADBEEF, 4'b0101, 0, 0, 0, 1'b0);
        axi_read(8'h04, 32'h00AD00EF, 2'b00);
        chk("active1_before_sof", 64'(regs_active[63:32]), 64'd0);

        pulse_sof();   // commits
        pulse_sof();   // nothing pending: no commit

        // Address first, data 3 cycles later; bready held low for 5 cycles.
        axi_write(8'h08, 32'h11223344, 4'hF, 0, 3, 5, 1'b0);
        rd_model(8'h08);
        // Data first, address 3 cycles later.
        axi_write(8'h0C, 32'h55667788, 4'hF, 3, 0, 0, 1'b0);
        rd_model(8'h0C);
        check_active("no_sof_yet");
        pulse_sof();

        // Out-of-range accesses; 0x20 must not alias register 0.
        axi_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0);
        rd_model(8'h00);
        rd_model(8'h20);
        axi_read(8'hFC, 32'h0, 2'b10);
        check_active("oor");

        // Write completing with a commit-eligible frame_sof.
        axi_write(8'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1'b0);
        axi_write(8'h10, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 1'b1);
        check_active("coincident");
        pulse_sof();
        // Write with frame_sof while nothing is pending: no commit.
        axi_write(8'h14, 32'hCAFEF00D, 4'b1000, 0, 0, 0, 1'b1);
        check_active("coincident_idle");
        pulse_sof();
        rd_model(8'h14);

`ifdef REGFILE_FRAME_COUNT_EN
        rd_model(8'h20);
        axi_write(8'h20, 32'h12345678, 4'hF, 0, 0, 0, 1'b0);
        rd_model(8'h20);
`endif

        // Reset during an outstanding read response.
        bus.araddr  = 8'h04;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        tick();
        chk("rvalid_before_reset", 64'(bus.rvalid), 64'd1);
        areset = 1'b1;
        tick();
        model_reset();
        chk("reset_drops_rvalid", 64'(bus.rvalid), 64'd0);
        chk("reset_rdata", 64'(bus.rdata), 64'd0);
        chk("reset_pending", 64'(regs_pending), 64'd0);
        check_active("midreset");
        areset = 1'b0;
        tick();
        rd_model(8'h04);
`ifdef REGFILE_FRAME_COUNT_EN
        rd_model(8'h20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
